regfile_access_arbiter: RTL and testbench

Sequencer and two-port round-robin arbiter in front of the single-write/single-read `register_file` (DEPTH=8, WIDTH=8 by default). It optionally clears every register after reset. It then serialises read and write commands from two requesters (A and B) onto the register file's `enable`/`write_*`/`read_*` ports, one command per grant, and returns read data through a registered valid pulse.

---
 rtl/regfile_access_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_access_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_arbiter.sv
// Two-requester round-robin arbiter and init sequencer in front of a 1W/1R register file.
// Define REGFILE_ARB_INIT_EN to zero every register with an INIT sweep after each reset.
module regfile_access_arbiter #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             req_b,
   input  logic             we_a,
   input  logic             we_b,
   input  logic [AW-1:0]    addr_a,
   input  logic [AW-1:0]    addr_b,
   input  logic [WIDTH-1:0] wdata_a,
   input  logic [WIDTH-1:0] wdata_b,
   output logic             ack_a,
   output logic             ack_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic             rvalid_a,
   output logic             rvalid_b,
   output logic             busy,
   output logic             rf_enable,
   output logic             rf_write_en,
   output logic [AW-1:0]    rf_write_addr,
   output logic [WIDTH-1:0] rf_write_data,
   output logic [AW-1:0]    rf_read_addr,
   input  logic [WIDTH-1:0] rf_read_data
);

`ifdef REGFILE_ARB_INIT_EN
   localparam logic [1:0] StInit  = 2'd0;
`endif
   localparam logic [1:0] StIdle  = 2'd1;
   localparam logic [1:0] StIssue = 2'd2;

`ifdef REGFILE_ARB_INIT_EN
   localparam logic [1:0] StReset = StInit;
   localparam logic [AW-1:0] InitLast = AW'(DEPTH - 1);
   logic [AW-1:0] init_cnt;
   logic          busy_q;
   assign busy = busy_q;
`else
   localparam logic [1:0] StReset = StIdle;
   assign busy = 1'b0;
`endif

   logic [1:0] state;
   logic       last_grant_b;  // 1: B was granted last, so A wins the next tie
   logic       issue_b;
   logic       issue_we;
   logic       grant_b;

   assign grant_b = req_b & (~req_a | ~last_grant_b);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= StReset;
         last_grant_b  <= 1'b1;
         issue_b       <= 1'b0;
         issue_we      <= 1'b0;
         ack_a         <= 1'b0;
         ack_b         <= 1'b0;
         rvalid_a      <= 1'b0;
         rvalid_b      <= 1'b0;
         rdata_a       <= '0;
         rdata_b       <= '0;
         rf_enable     <= 1'b0;
         rf_write_en   <= 1'b0;
         rf_write_addr <= '0;
         rf_write_data <= '0;
         rf_read_addr  <= '0;
`ifdef REGFILE_ARB_INIT_EN
         busy_q        <= 1'b0;
         init_cnt      <= '0;
`endif
      end else begin
         ack_a    <= 1'b0;
         ack_b    <= 1'b0;
         rvalid_a <= 1'b0;
         rvalid_b <= 1'b0;
         case (state)
`ifdef REGFILE_ARB_INIT_EN
            StInit: begin
               rf_enable     <= 1'b1;
               rf_write_en   <= 1'b1;
               rf_write_addr <= init_cnt;
               rf_write_data <= '0;
               busy_q        <= 1'b1;
               init_cnt      <= init_cnt + 1'b1;
               if (init_cnt == InitLast) begin
                  state <= StIdle;
               end
            end
`endif
            StIdle: begin
               rf_enable   <= 1'b1;
               rf_write_en <= 1'b0;
`ifdef REGFILE_ARB_INIT_EN
               busy_q      <= 1'b0;
`endif
               if (req_a || req_b) begin
                  issue_b       <= grant_b;
                  last_grant_b  <= grant_b;
                  issue_we      <= grant_b ? we_b : we_a;
                  rf_write_en   <= grant_b ? we_b : we_a;
                  rf_write_addr <= grant_b ? addr_b : addr_a;
                  rf_read_addr  <= grant_b ? addr_b : addr_a;
                  rf_write_data <= grant_b ? wdata_b : wdata_a;
                  ack_a         <= ~grant_b;
                  ack_b         <= grant_b;
                  state         <= StIssue;
               end
            end
            StIssue: begin
               rf_write_en <= 1'b0;
               // Read data is combinational from rf_read_addr, so capture it as ISSUE ends.
               if (!issue_we) begin
                  if (issue_b) begin
                     rdata_b  <= rf_read_data;
                     rvalid_b <= 1'b1;
                  end else begin
                     rdata_a  <= rf_read_data;
                     rvalid_a <= 1'b1;
                  end
               end
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a behavioural 8x8 register file model.
// Follows REGFILE_ARB_INIT_EN to expect or skip the INIT sweep.
module tb_regfile_access_arbiter;

   logic       clk;
   logic       rst;
   logic       req_a, req_b, we_a, we_b;
   logic [2:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic       ack_a, ack_b, rvalid_a, rvalid_b, busy;
   logic [7:0] rdata_a, rdata_b;
   logic       rf_enable, rf_write_en;
   logic [2:0] rf_write_addr, rf_read_addr;
   logic [7:0] rf_write_data, rf_read_data;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [8];

   regfile_access_arbiter #(.DEPTH(8), .WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_a         (req_a),
      .req_b         (req_b),
      .we_a          (we_a),
      .we_b          (we_b),
      .addr_a        (addr_a),
      .addr_b        (addr_b),
      .wdata_a       (wdata_a),
      .wdata_b       (wdata_b),
      .ack_a         (ack_a),
      .ack_b         (ack_b),
      .rdata_a       (rdata_a),
      .rdata_b       (rdata_b),
      .rvalid_a      (rvalid_a),
      .rvalid_b      (rvalid_b),
      .busy          (busy),
      .rf_enable     (rf_enable),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data),
      .rf_read_addr  (rf_read_addr),
      .rf_read_data  (rf_read_data)
   );

   // Register file: synchronous clear on reset, synchronous write, combinational read.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      end else if (rf_enable && rf_write_en) begin
         mem[rf_write_addr] <= rf_write_data;
      end
   end
   assign rf_read_data = mem[rf_read_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic init_sweep();
`ifdef REGFILE_ARB_INIT_EN
      for (int k = 0; k < 8; k++) begin
         tick();
         check("init_busy", 32'(busy), 32'd1);
         check("init_we", 32'(rf_write_en), 32'd1);
         check("init_addr", 32'(rf_write_addr), 32'(k));
         check("init_data", 32'(rf_write_data), 32'd0);
      end
`endif
   endtask

   // Issue one command at the current negedge; checks ack cycle and the following cycle.
   task automatic do_cmd(input logic b, input logic we, input logic [2:0] addr,
                         input logic [7:0] data, input logic [7:0] exp);
      if (b) begin
         req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = data;
      end else begin
         req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = data;
      end
      tick();
      check("ack_win", 32'(b ? ack_b : ack_a), 32'd1);
      check("ack_lose", 32'(b ? ack_a : ack_b), 32'd0);
      check("rf_we", 32'(rf_write_en), 32'(we));
      if (we) begin
         check("rf_waddr", 32'(rf_write_addr), 32'(addr));
         check("rf_wdata", 32'(rf_write_data), 32'(data));
      end else begin
         check("rf_raddr", 32'(rf_read_addr), 32'(addr));
      end
      req_a = 1'b0;
      req_b = 1'b0;
      tick();
      check("rvalid", 32'(b ? rvalid_b : rvalid_a), 32'(!we));
      if (!we) check("rdata", 32'(b ? rdata_b : rdata_a), 32'(exp));
   endtask

   initial begin
      rst = 1'b0;
      req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
      addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
      tick();
      tick();
      check("rst_ack_a", 32'(ack_a), 32'd0);
      check("rst_ack_b", 32'(ack_b), 32'd0);
      check("rst_rvalid_a", 32'(rvalid_a), 32'd0);
      check("rst_rvalid_b", 32'(rvalid_b), 32'd0);
      check("rst_rf_enable", 32'(rf_enable), 32'd0);
      check("rst_rf_we", 32'(rf_write_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata_a", 32'(rdata_a), 32'd0);
      rst = 1'b1;
      init_sweep();

      // Tie right after reset: A first, then B.
      req_a = 1'b1; we_a = 1'b1; addr_a = 3'd6; wdata_a = 8'h10;
      req_b = 1'b1; we_b = 1'b1; addr_b = 3'd6; wdata_b = 8'h20;
      tick();
      check("tie1_ack_a", 32'(ack_a), 32'd1);
      check("tie1_ack_b", 32'(ack_b), 32'd0);
      check("tie1_data", 32'(rf_write_data), 32'h10);
      check("busy_after_init", 32'(busy), 32'd0);
      req_a = 1'b0;
      tick();
      check("tie_idle", 32'({ack_a, ack_b}), 32'd0);
      tick();
      check("tie2_ack_a", 32'(ack_a), 32'd0);
      check("tie2_ack_b", 32'(ack_b), 32'd1);
      check("tie2_data", 32'(rf_write_data), 32'h20);
      req_b = 1'b0;
      tick();
      do_cmd(1'b0, 1'b0, 3'd6, 8'h00, 8'h20);

      do_cmd(1'b0, 1'b0, 3'd5, 8'h00, 8'h00);
      do_cmd(1'b0, 1'b1, 3'd4, 8'h01, 8'h00);
      do_cmd(1'b0, 1'b0, 3'd4, 8'h00, 8'h01);

      // Sustained contention; A was granted last, so B leads.
      req_a = 1'b1; we_a = 1'b1; addr_a = 3'd0; wdata_a = 8'hAA;
      req_b = 1'b1; we_b = 1'b1; addr_b = 3'd1; wdata_b = 8'hBB;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rr_ack", 32'({ack_a, ack_b}), (i % 2 == 0) ? 32'b01 : 32'b10);
         if (i == 7) begin
            req_a = 1'b0;
            req_b = 1'b0;
         end
         tick();
         check("rr_gap", 32'({ack_a, ack_b}), 32'd0);
      end
      do_cmd(1'b1, 1'b0, 3'd1, 8'h00, 8'hBB);
      check("rdata_a_hold", 32'(rdata_a), 32'h01);

      for (int a = 7; a >= 0; a--) do_cmd(1'b0, 1'b1, 3'(a), 8'(a), 8'h00);
      for (int a = 0; a < 8; a++) do_cmd(1'b0, 1'b0, 3'(a), 8'h00, 8'(a));

      // Reset during the ISSUE cycle of a write.
      req_a = 1'b1; we_a = 1'b1; addr_a = 3'd2; wdata_a = 8'hFF;
      tick();
      check("mid_ack", 32'(ack_a), 32'd1);
      rst = 1'b0;
      req_a = 1'b0;
      tick();
      check("mid_ack_clr", 32'(ack_a), 32'd0);
      check("mid_rvalid_clr", 32'({rvalid_a, rvalid_b}), 32'd0);
      check("mid_we_clr", 32'(rf_write_en), 32'd0);
      rst = 1'b1;
      init_sweep();
      do_cmd(1'b0, 1'b0, 3'd2, 8'h00, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
